// File: rtl/ahb_conv_batch_ctrl.sv
// AHB-Lite register slave that sequences a multi-channel convolution batch:
// it launches the core once per channel, advancing the strided in/out base addresses.
module ahb_conv_batch_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 8,
    parameter int MAX_CH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              core_start,
    output logic              core_srst,
    input  logic              core_done,
    output logic [DIM_W-1:0]  core_N,
    output logic [DIM_W-1:0]  core_K,
    output logic [ADDR_W-1:0] core_base_in,
    output logic [ADDR_W-1:0] core_base_k,
    output logic [ADDR_W-1:0] core_base_out,
    output logic              irq
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_FINISH} state_t;

    localparam logic [7:0] MAX_CH_L = 8'(MAX_CH);

    state_t             state_q;
    logic               hsel_q, hwrite_q, htrans1_q;
    logic [7:0]         haddr_q;
    logic               irq_en_q, done_q, err_q, irq_q, wait_first_q;
    logic               core_start_q, core_srst_q;
    logic [DIM_W-1:0]   n_q, k_q;
    logic [ADDR_W-1:0]  base_in_q, base_k_q, base_out_q, in_stride_q, out_stride_q;
    logic [ADDR_W-1:0]  acc_in_q, acc_out_q;
    logic [7:0]         num_ch_q, ch_q;
    logic [31:0]        cycles_q;

    logic busy, wr_en, wr_ctrl, wr_status, cfg_wr, cfg_ok;
    logic start_req, abort_req, num_ok, last_ch;
    logic unused_bits;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign busy      = (state_q != S_IDLE);
    assign wr_en     = hsel_q & htrans1_q & hwrite_q;
    assign wr_ctrl   = wr_en && (haddr_q == 8'h00);
    assign wr_status = wr_en && (haddr_q == 8'h04);
    assign cfg_wr    = wr_en && (haddr_q >= 8'h08) && (haddr_q <= 8'h24) && (haddr_q[1:0] == 2'b00);
    assign cfg_ok    = cfg_wr & ~busy;
    // ABORT takes precedence over START written in the same transfer.
    assign abort_req = wr_ctrl & HWDATA[2];
    assign start_req = wr_ctrl & HWDATA[0] & ~HWDATA[2];
    assign num_ok    = (num_ch_q != 8'd0) && (num_ch_q <= MAX_CH_L);
    assign last_ch   = (ch_q == num_ch_q - 8'd1);

    assign unused_bits = ^{HADDR[31:8], HTRANS[0], HWDATA[31:ADDR_W]};

    assign core_start    = core_start_q;
    assign core_srst     = core_srst_q;
    assign core_N        = n_q;
    assign core_K        = k_q;
    assign core_base_in  = acc_in_q;
    assign core_base_k   = base_k_q;
    assign core_base_out = acc_out_q;
    assign irq           = irq_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsel_q    <= 1'b0;
            hwrite_q  <= 1'b0;
            htrans1_q <= 1'b0;
            haddr_q   <= 8'h00;
        end else if (HREADY) begin
            hsel_q    <= HSEL;
            hwrite_q  <= HWRITE;
            htrans1_q <= HTRANS[1];
            haddr_q   <= HADDR[7:0];
        end
    end

    always_comb begin
        HRDATA = '0;
        case (haddr_q)
            8'h00: HRDATA[1] = irq_en_q;
            8'h04: HRDATA = {16'h0000, ch_q, 5'b00000, err_q, done_q, busy};
            8'h08: HRDATA[DIM_W-1:0] = n_q;
            8'h0C: HRDATA[DIM_W-1:0] = k_q;
            8'h10: HRDATA[ADDR_W-1:0] = base_in_q;
            8'h14: HRDATA[ADDR_W-1:0] = base_k_q;
            8'h18: HRDATA[ADDR_W-1:0] = base_out_q;
            8'h1C: HRDATA[7:0] = num_ch_q;
            8'h20: HRDATA[ADDR_W-1:0] = in_stride_q;
            8'h24: HRDATA[ADDR_W-1:0] = out_stride_q;
            8'h28: HRDATA = cycles_q;
            default: ;
        endcase
    end

    // Hardware sets are written after the W1C clears so a coincident set wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            wait_first_q <= 1'b0;
            core_start_q <= 1'b0;
            core_srst_q  <= 1'b0;
            n_q          <= '0;
            k_q          <= '0;
            base_in_q    <= '0;
            base_k_q     <= '0;
            base_out_q   <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            acc_in_q     <= '0;
            acc_out_q    <= '0;
            num_ch_q     <= 8'd0;
            ch_q         <= 8'd0;
            cycles_q     <= 32'd0;
        end else begin
            core_start_q <= 1'b0;
            core_srst_q  <= 1'b0;
            irq_q        <= irq_en_q & (done_q | err_q);
            if (wr_ctrl) irq_en_q <= HWDATA[1];
            if (cfg_ok) begin
                case (haddr_q)
                    8'h08: n_q          <= HWDATA[DIM_W-1:0];
                    8'h0C: k_q          <= HWDATA[DIM_W-1:0];
                    8'h10: base_in_q    <= HWDATA[ADDR_W-1:0];
                    8'h14: base_k_q     <= HWDATA[ADDR_W-1:0];
                    8'h18: base_out_q   <= HWDATA[ADDR_W-1:0];
                    8'h1C: num_ch_q     <= HWDATA[7:0];
                    8'h20: in_stride_q  <= HWDATA[ADDR_W-1:0];
                    8'h24: out_stride_q <= HWDATA[ADDR_W-1:0];
                    default: ;
                endcase
            end
            if (wr_status) begin
                if (HWDATA[1]) done_q <= 1'b0;
                if (HWDATA[2]) err_q  <= 1'b0;
            end
            if (cfg_wr && busy) err_q <= 1'b1;
            if (busy && (cycles_q != 32'hFFFF_FFFF)) cycles_q <= cycles_q + 32'd1;

            if (busy && abort_req) begin
                state_q     <= S_IDLE;
                core_srst_q <= 1'b1;
                err_q       <= 1'b1;
                done_q      <= 1'b0;
            end else begin
                if (busy && start_req) err_q <= 1'b1;
                case (state_q)
                    S_IDLE: begin
                        if (start_req) begin
                            if (num_ok) begin
                                ch_q         <= 8'd0;
                                acc_in_q     <= base_in_q;
                                acc_out_q    <= base_out_q;
                                cycles_q     <= 32'd0;
                                done_q       <= 1'b0;
                                core_start_q <= 1'b1;
                                state_q      <= S_LAUNCH;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        wait_first_q <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                    // The first WAIT cycle ignores a done level left over from the previous job.
                    S_WAIT: begin
                        if (wait_first_q) wait_first_q <= 1'b0;
                        else if (core_done) state_q <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (last_ch) begin
                            state_q <= S_FINISH;
                        end else begin
                            ch_q         <= ch_q + 8'd1;
                            acc_in_q     <= acc_in_q + in_stride_q;
                            acc_out_q    <= acc_out_q + out_stride_q;
                            core_start_q <= 1'b1;
                            state_q      <= S_LAUNCH;
                        end
                    end
                    S_FINISH: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_conv_batch_ctrl.sv
// Directed bench for ahb_conv_batch_ctrl: register table, batch sequences,
// error, abort, stale-done and mid-batch reset cases against a simple core model.
module tb_ahb_conv_batch_ctrl;

    localparam int ADDR_W = 18;
    localparam int DIM_W  = 8;
    localparam int MAX_CH = 4;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              HSEL, HWRITE, HREADY;
    logic [1:0]        HTRANS;
    logic [31:0]       HADDR, HWDATA;
    logic              HREADYOUT, HRESP;
    logic [31:0]       HRDATA;
    logic              core_start, core_srst, core_done;
    logic [DIM_W-1:0]  core_N, core_K;
    logic [ADDR_W-1:0] core_base_in, core_base_k, core_base_out;
    logic              irq;

    ahb_conv_batch_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .MAX_CH(MAX_CH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .core_start(core_start), .core_srst(core_srst),
        .core_done(core_done), .core_N(core_N), .core_K(core_K),
        .core_base_in(core_base_in), .core_base_k(core_base_k),
        .core_base_out(core_base_out), .irq(irq)
    );

    // ---------------- clock ----------------
    always #5 HCLK = ~HCLK;

    // ---------------- core model and monitor ----------------
    int                lat = 5;
    int                cnt = 0;
    logic              mdone = 1'b0;
    logic              stale_done = 1'b0;
    int                start_cnt = 0;
    int                srst_cnt = 0;
    logic [ADDR_W-1:0] got_in_q[$];
    logic [ADDR_W-1:0] got_out_q[$];
    logic [ADDR_W-1:0] exp_in_q[$];
    logic [ADDR_W-1:0] exp_out_q[$];

    assign core_done = mdone | stale_done;

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (core_start) begin
                start_cnt++;
                got_in_q.push_back(core_base_in);
                got_out_q.push_back(core_base_out);
            end
            if (core_srst) srst_cnt++;
        end
        if (core_start) begin
            cnt   = lat;
            mdone = 1'b0;
        end else if (cnt > 0) begin
            cnt--;
            mdone = (cnt == 0);
        end else begin
            mdone = 1'b0;
        end
    end

    // ---------------- scoreboard helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        logic        ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ahb_rd(8'h04, s);
            if (!s[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic chk_launches(input string name);
        logic [ADDR_W-1:0] e, g;
        while (exp_in_q.size() > 0) begin
            e = exp_in_q.pop_front();
            g = (got_in_q.size() > 0) ? got_in_q.pop_front() : '1;
            chk({name, "_in"}, 32'(g), 32'(e));
            e = exp_out_q.pop_front();
            g = (got_out_q.size() > 0) ? got_out_q.pop_front() : '1;
            chk({name, "_out"}, 32'(g), 32'(e));
        end
        chk({name, "_extra"}, got_in_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        vt[0]  = '{8'h08, 32'h0000_01FF, 32'h0000_00FF};
        vt[1]  = '{8'h0C, 32'h0000_00A5, 32'h0000_00A5};
        vt[2]  = '{8'h10, 32'hFFFF_FFFF, 32'h0003_FFFF};
        vt[3]  = '{8'h14, 32'h0001_2345, 32'h0001_2345};
        vt[4]  = '{8'h18, 32'h0004_0000, 32'h0000_0000};
        vt[5]  = '{8'h1C, 32'h0000_1234, 32'h0000_0034};
        vt[6]  = '{8'h20, 32'h0003_ABCD, 32'h0003_ABCD};
        vt[7]  = '{8'h24, 32'h0005_5555, 32'h0001_5555};
        vt[8]  = '{8'h28, 32'h0000_DEAD, 32'h0000_0000};
        vt[9]  = '{8'h30, 32'h0000_1234, 32'h0000_0000};
        vt[10] = '{8'h00, 32'h0000_0002, 32'h0000_0002};
        vt[11] = '{8'h00, 32'h0000_0000, 32'h0000_0000};
        vt[12] = '{8'h04, 32'h0000_0006, 32'h0000_0000};

        HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HREADY = 1'b1;
        HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
        repeat (3) @(negedge HCLK);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_outs", {28'h0, core_start, core_srst, irq, |core_base_in}, 32'h0);
        HRESETn = 1'b1;
        rd_chk("rst_status", 8'h04, 32'h0);

        // register table
        for (int i = 0; i < 13; i++) begin
            ahb_wr(vt[i].addr, vt[i].wdata);
            rd_chk($sformatf("reg_%0h", vt[i].addr), vt[i].addr, vt[i].exp);
        end

        // single-channel batch
        lat = 5;
        ahb_wr(8'h08, 8); ahb_wr(8'h0C, 3); ahb_wr(8'h10, 32'h100);
        ahb_wr(8'h14, 32'h300); ahb_wr(8'h18, 32'h200); ahb_wr(8'h1C, 1);
        ahb_wr(8'h20, 0); ahb_wr(8'h24, 0);
        s0 = start_cnt;
        exp_in_q.push_back(18'h00100); exp_out_q.push_back(18'h00200);
        ahb_wr(8'h00, 32'h1);
        wait_idle("single_idle");
        chk("single_starts", start_cnt - s0, 1);
        rd_chk("single_status", 8'h04, 32'h0000_0002);
        rd_chk("single_cycles", 8'h28, 32'd8);
        chk("single_N", 32'(core_N), 32'd8);
        chk("single_K", 32'(core_K), 32'd3);
        chk("single_base_k", 32'(core_base_k), 32'h300);
        chk_launches("single");

        // strided batch
        ahb_wr(8'h04, 32'h6);
        lat = 3;
        ahb_wr(8'h1C, 3); ahb_wr(8'h10, 32'h1000); ahb_wr(8'h18, 32'h2000);
        ahb_wr(8'h20, 32'h40); ahb_wr(8'h24, 32'h20);
        s0 = start_cnt;
        exp_in_q.push_back(18'h01000); exp_out_q.push_back(18'h02000);
        exp_in_q.push_back(18'h01040); exp_out_q.push_back(18'h02020);
        exp_in_q.push_back(18'h01080); exp_out_q.push_back(18'h02040);
        ahb_wr(8'h00, 32'h1);
        wait_idle("stride_idle");
        chk("stride_starts", start_cnt - s0, 3);
        rd_chk("stride_status", 8'h04, 32'h0000_0202);
        rd_chk("stride_cycles", 8'h28, 32'd16);
        chk_launches("stride");

        // address wrap-around
        ahb_wr(8'h04, 32'h6);
        ahb_wr(8'h1C, 2); ahb_wr(8'h10, 32'h3FFF0); ahb_wr(8'h20, 32'h20);
        exp_in_q.push_back(18'h3FFF0); exp_out_q.push_back(18'h02000);
        exp_in_q.push_back(18'h00010); exp_out_q.push_back(18'h02020);
        ahb_wr(8'h00, 32'h1);
        wait_idle("wrap_idle");
        rd_chk("wrap_status", 8'h04, 32'h0000_0102);
        chk_launches("wrap");

        // illegal channel counts
        ahb_wr(8'h04, 32'h6);
        ahb_wr(8'h1C, 0);
        s0 = start_cnt;
        ahb_wr(8'h00, 32'h1);
        rd_chk("nch0_status", 8'h04, 32'h0000_0104);
        ahb_wr(8'h04, 32'h4);
        ahb_wr(8'h1C, 5);
        ahb_wr(8'h00, 32'h1);
        rd_chk("nch5_status", 8'h04, 32'h0000_0104);
        repeat (5) @(negedge HCLK);
        chk("nch_bad_starts", start_cnt - s0, 0);

        // config write and START while busy
        ahb_wr(8'h04, 32'h6);
        lat = 40;
        ahb_wr(8'h1C, 1);
        s0 = start_cnt;
        ahb_wr(8'h00, 32'h1);
        ahb_wr(8'h08, 32'h55);
        rd_chk("busy_wr_status", 8'h04, 32'h0000_0005);
        ahb_wr(8'h00, 32'h1);
        wait_idle("busy_idle");
        rd_chk("busy_N_kept", 8'h08, 32'd8);
        chk("busy_starts", start_cnt - s0, 1);
        rd_chk("busy_status", 8'h04, 32'h0000_0006);
        rd_chk("busy_cycles", 8'h28, 32'd43);
        got_in_q.delete(); got_out_q.delete();

        // abort during channel 1 with interrupt enabled
        ahb_wr(8'h04, 32'h6);
        lat = 30;
        ahb_wr(8'h1C, 3);
        s0 = start_cnt;
        ahb_wr(8'h00, 32'h3);
        for (int i = 0; i < 500 && start_cnt < s0 + 2; i++) @(negedge HCLK);
        chk("abort_reach_ch1", start_cnt - s0, 2);
        repeat (3) @(negedge HCLK);
        chk("abort_pre_irq", {31'h0, irq}, 32'h0);
        ahb_wr(8'h00, 32'h6);
        rd_chk("abort_status", 8'h04, 32'h0000_0104);
        chk("abort_srst", srst_cnt, 1);
        chk("abort_irq_set", {31'h0, irq}, 32'h1);
        ahb_wr(8'h04, 32'h4);
        rd_chk("abort_w1c_status", 8'h04, 32'h0000_0100);
        chk("abort_irq_clr", {31'h0, irq}, 32'h0);
        repeat (50) @(negedge HCLK);
        chk("abort_no_more_starts", start_cnt - s0, 2);
        got_in_q.delete(); got_out_q.delete();

        // START+ABORT together while idle does nothing
        s0 = start_cnt;
        ahb_wr(8'h00, 32'h5);
        repeat (10) @(negedge HCLK);
        chk("startabort_starts", start_cnt - s0, 0);
        rd_chk("startabort_status", 8'h04, 32'h0000_0100);

        // stale done held across LAUNCH and the first WAIT cycle
        lat = 5;
        ahb_wr(8'h1C, 1);
        s0 = start_cnt;
        stale_done = 1'b1;
        ahb_wr(8'h00, 32'h1);
        repeat (3) @(negedge HCLK);
        stale_done = 1'b0;
        wait_idle("stale_idle");
        chk("stale_starts", start_cnt - s0, 1);
        rd_chk("stale_cycles", 8'h28, 32'd8);
        rd_chk("stale_status", 8'h04, 32'h0000_0002);
        got_in_q.delete(); got_out_q.delete();

        // reset in the middle of a batch
        lat = 30;
        ahb_wr(8'h1C, 2);
        ahb_wr(8'h00, 32'h1);
        repeat (5) @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("midrst_outs", {28'h0, core_start, core_srst, irq, |core_base_out}, 32'h0);
        chk("midrst_hready", {30'h0, HREADYOUT, HRESP}, 32'h2);
        s0 = start_cnt;
        HRESETn = 1'b1;
        repeat (60) @(negedge HCLK);
        chk("midrst_starts", start_cnt - s0, 0);
        rd_chk("midrst_N", 8'h08, 32'h0);
        rd_chk("midrst_status", 8'h04, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_conv_batch_ctrl.md
AHB_CONV_BATCH_CTRL -- requirements
Module: ahb_conv_batch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, which sets the width of the memory base addresses.
REQ-002 The block SHALL have parameter DIM_W, default 8, which sets the width of the image size N and the kernel size K.
REQ-003 The block SHALL have parameter MAX_CH, default 4, which sets the maximum number of channels per batch (1..255).
REQ-004 The block SHALL have one clock, HCLK, and an asynchronous active-low reset, HRESETn.
REQ-005 The port list SHALL be, in this order:
- HCLK  in  1  clock
- HRESETn  in  1  async reset, active low
- HSEL, HWRITE, HREADY  in  1 each  AHB-Lite slave controls
- HTRANS  in  2  transfer type
- HADDR, HWDATA  in  32 each  address and write data
- HREADYOUT  out  1  always 1
- HRESP  out  1  always 0 (OKAY)
- HRDATA  out  32  read data
- core_start  out  1  one-cycle job launch pulse
- core_srst  out  1  one-cycle core reset pulse on abort
- core_done  in  1  job complete from the convolution core
- core_N, core_K  out  DIM_W each  job dimensions
- core_base_in, core_base_k, core_base_out  out  ADDR_W each  per-channel base addresses
- irq  out  1  interrupt, level

Function
REQ-006 The block SHALL register HSEL, HWRITE, HTRANS and HADDR[7:0] in the address phase when HREADY=1; a write commits HWDATA in the data phase when HTRANS[1]&HWRITE&HSEL are set.
REQ-007 The register map SHALL be:
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN, bit2 ABORT (write-1 pulse)
- 0x04 STATUS: bit0 BUSY, bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C), bits[15:8] current channel
- 0x08 N, 0x0C K, 0x10 BASE_IN, 0x14 BASE_K, 0x18 BASE_OUT, 0x1C NUM_CH, 0x20 IN_STRIDE, 0x24 OUT_STRIDE
- 0x28 CYCLES (read-only)
- unmapped addresses read 0 and ignore writes
REQ-008 HRDATA SHALL be combinational from the registered data-phase address, with unused bits zero.
REQ-009 Writes to 0x08-0x24 while BUSY=1 SHALL be ignored, and ERR SHALL be set.
REQ-010 The FSM states SHALL be IDLE, LAUNCH, WAIT, NEXT and FINISH.
REQ-011 In IDLE, START with NUM_CH in 1..MAX_CH SHALL:
- load channel=0
- load the in/out address accumulators with BASE_IN/BASE_OUT
- clear CYCLES and DONE
- go to LAUNCH
REQ-012 In IDLE, START with NUM_CH=0 or NUM_CH>MAX_CH SHALL set ERR and stay in IDLE.
REQ-013 START while BUSY=1 SHALL set ERR and SHALL NOT disturb the batch.
REQ-014 LAUNCH SHALL assert core_start for exactly one cycle, then go to WAIT.
REQ-015 WAIT SHALL ignore core_done in its first cycle (stale-level guard).
REQ-016 From the second cycle of WAIT onward, core_done=1 SHALL move the FSM to NEXT.
REQ-017 NEXT SHALL go to FINISH if channel==NUM_CH-1.
REQ-018 Otherwise NEXT SHALL:
- increment channel
- add IN_STRIDE to the in accumulator and OUT_STRIDE to the out accumulator, modulo 2^ADDR_W
- go to LAUNCH
REQ-019 FINISH SHALL set DONE and return to IDLE after one cycle.
REQ-020 core_base_in and core_base_out SHALL be driven from the accumulators; core_base_k, core_N and core_K SHALL be driven from the registers directly.
REQ-021 BUSY SHALL be 1 in every state except IDLE.
REQ-022 CYCLES SHALL increment each cycle that BUSY=1 and SHALL saturate at all-ones.
REQ-023 ABORT in any non-IDLE state SHALL force IDLE the next cycle, pulse core_srst for one cycle, set ERR and leave DONE clear.
REQ-024 ABORT in IDLE SHALL have no effect.
REQ-025 START and ABORT written in the same transfer SHALL resolve to ABORT.
REQ-026 A W1C write coincident with a hardware set of the same bit SHALL leave the bit set.
REQ-027 irq SHALL be registered and equal IRQ_EN & (DONE | ERR).

Reset
REQ-028 On HRESETn=0, asynchronously, the block SHALL:
- clear all registers, flags and the FSM to IDLE
- drive core_start=0, core_srst=0, irq=0 and all core_* buses to 0
REQ-029 Reset mid-batch SHALL abandon the batch with no core_start pulse after reset release.
REQ-030 HREADYOUT=1 and HRESP=0 SHALL hold at all times, including during reset.

Verification
REQ-031 The bench SHALL cover a single-channel batch: N=8, K=3, BASE_IN=0x100, NUM_CH=1, START -> one core_start pulse, done after 5 cycles, DONE=1, BUSY=0, CYCLES equal to the busy cycles.
REQ-032 The bench SHALL cover a strided batch: NUM_CH=3, BASE_IN=0x1000, IN_STRIDE=0x40, OUT_STRIDE=0x20, BASE_OUT=0x2000 -> core_base_in 0x1000/0x1040/0x1080 and core_base_out 0x2000/0x2020/0x2040, three core_start pulses.
REQ-033 The bench SHALL cover wrap-around: BASE_IN=0x3FFF0, IN_STRIDE=0x20, NUM_CH=2 -> second core_base_in=0x00010.
REQ-034 The bench SHALL cover errors:
- NUM_CH=0 then START -> ERR=1, no core_start
- N write while BUSY -> N unchanged, ERR=1
REQ-035 The bench SHALL cover abort: ABORT during WAIT of channel 1 -> core_srst pulse, IDLE, ERR=1, DONE=0; with IRQ_EN=1, irq=1 until ERR is cleared by W1C.
REQ-036 The bench SHALL cover a stale done: core_done held high across LAUNCH -> no premature exit from WAIT in the first WAIT cycle.
